tcdm_bridge_resp_sched: RTL and testbench

//   Response scheduler in front of the XBAR bridge response fan-in tree. It captures one

---
 rtl/tcdm_bridge_resp_sched_if.sv | 29 ++
 rtl/tcdm_bridge_resp_sched.sv | 113 +++++++++++
 tb/tb_tcdm_bridge_resp_sched.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_bridge_resp_sched_if.sv
// Slave-response / fan-in-tree bundle of the response scheduler.
// The slave modport is the scheduler's view; master is the surrounding fabric.
interface tcdm_bridge_resp_sched_if #(
   parameter int N_SLAVE    = 16,
   parameter int DATA_WIDTH = 32,
   parameter int AUX_WIDTH  = 8
);
   logic [N_SLAVE-1:0]            slv_valid_i;
   logic [N_SLAVE*DATA_WIDTH-1:0] slv_rdata_i;
   logic [N_SLAVE-1:0]            slv_opc_i;
   logic [N_SLAVE*AUX_WIDTH-1:0]  slv_aux_i;
   logic [N_SLAVE-1:0]            slv_ready_o;
   logic [N_SLAVE-1:0]            tree_valid_o;
   logic [N_SLAVE*DATA_WIDTH-1:0] tree_rdata_o;
   logic [N_SLAVE-1:0]            tree_opc_o;
   logic [N_SLAVE*AUX_WIDTH-1:0]  tree_aux_o;
   logic                          mst_ready_i;
   logic                          busy_o;

   modport slave (
      input  slv_valid_i, slv_rdata_i, slv_opc_i, slv_aux_i, mst_ready_i,
      output slv_ready_o, tree_valid_o, tree_rdata_o, tree_opc_o, tree_aux_o, busy_o
   );

   modport master (
      output slv_valid_i, slv_rdata_i, slv_opc_i, slv_aux_i, mst_ready_i,
      input  slv_ready_o, tree_valid_o, tree_rdata_o, tree_opc_o, tree_aux_o, busy_o
   );
endinterface

// File: rtl/tcdm_bridge_resp_sched.sv
// Per-slave single-entry hold registers granted one-hot, round-robin, into the fan-in tree.
// Capture-to-tree latency 1 cycle; a stalled master locks the grant until mst_ready_i.
module tcdm_bridge_resp_sched #(
   parameter int N_SLAVE    = 16,
   parameter int DATA_WIDTH = 32,
   parameter int AUX_WIDTH  = 8
) (
   input logic                    clk,
   input logic                    rst,
   tcdm_bridge_resp_sched_if.slave bus
);
   localparam int PW = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

   typedef enum logic {ARB, LOCK} state_t;

   state_t                        state_q;
   logic [N_SLAVE-1:0]            occ_q;
   logic [N_SLAVE*DATA_WIDTH-1:0] rdata_q;
   logic [N_SLAVE-1:0]            opc_q;
   logic [N_SLAVE*AUX_WIDTH-1:0]  aux_q;
   logic [PW-1:0]                 ptr_q;
   logic [PW-1:0]                 lock_idx_q;

   logic [PW-1:0]                 gnt_idx;
   logic [PW-1:0]                 ptr_nxt;
   logic                          gnt_any;
   logic                          hs;
   logic [N_SLAVE-1:0]            tree_valid;
   logic [N_SLAVE-1:0]            slv_ready;
   logic [N_SLAVE-1:0]            cap;

   // Scan from the far end back towards ptr_q so the slot nearest ptr_q wins.
   always_comb begin
      int j;
      j       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (state_q == LOCK) begin
         gnt_any = 1'b1;
         gnt_idx = lock_idx_q;
      end else begin
         for (int k = N_SLAVE - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_SLAVE) j = j - N_SLAVE;
            if (occ_q[j]) begin
               gnt_any = 1'b1;
               gnt_idx = PW'(j);
            end
         end
      end
   end

   always_comb begin
      tree_valid = '0;
      if (!rst && gnt_any) tree_valid[gnt_idx] = 1'b1;
   end

   assign hs        = gnt_any & bus.mst_ready_i & ~rst;
   assign ptr_nxt   = (gnt_idx == PW'(N_SLAVE - 1)) ? '0 : gnt_idx + PW'(1);
   assign slv_ready = rst ? '0 : (~occ_q | (tree_valid & {N_SLAVE{bus.mst_ready_i}}));
   assign cap       = bus.slv_valid_i & slv_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         occ_q      <= '0;
         ptr_q      <= '0;
         lock_idx_q <= '0;
         rdata_q    <= '0;
         opc_q      <= '0;
         aux_q      <= '0;
      end else begin
         // A refill in the same cycle as the grant-clear keeps the slot occupied.
         for (int i = 0; i < N_SLAVE; i++) begin
            if (cap[i]) begin
               occ_q[i]                             <= 1'b1;
               rdata_q[i*DATA_WIDTH +: DATA_WIDTH]  <= bus.slv_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
               opc_q[i]                             <= bus.slv_opc_i[i];
               aux_q[i*AUX_WIDTH +: AUX_WIDTH]      <= bus.slv_aux_i[i*AUX_WIDTH +: AUX_WIDTH];
            end else if (hs && (gnt_idx == PW'(i))) begin
               occ_q[i] <= 1'b0;
            end
         end

         case (state_q)
            ARB: begin
               if (gnt_any) begin
                  if (bus.mst_ready_i) begin
                     ptr_q <= ptr_nxt;
                  end else begin
                     state_q    <= LOCK;
                     lock_idx_q <= gnt_idx;
                  end
               end
            end
            LOCK: begin
               if (bus.mst_ready_i) begin
                  ptr_q   <= ptr_nxt;
                  state_q <= ARB;
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

   assign bus.slv_ready_o  = slv_ready;
   assign bus.tree_valid_o = tree_valid;
   assign bus.tree_rdata_o = rdata_q;
   assign bus.tree_opc_o   = opc_q;
   assign bus.tree_aux_o   = aux_q;
   assign bus.busy_o       = |occ_q;
endmodule

// File: tb/tb_tcdm_bridge_resp_sched.sv
// Scoreboard bench for the response scheduler at N_SLAVE=4: expected grants are queued
// in grant order as responses are driven and compared as the tree presents them.
module tb_tcdm_bridge_resp_sched;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 8;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        opc;
      logic [7:0]  aux;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   vectors;
   int   miscompares;

   tcdm_bridge_resp_sched_if #(.N_SLAVE(N), .DATA_WIDTH(DW), .AUX_WIDTH(AW)) bus ();

   tcdm_bridge_resp_sched #(.N_SLAVE(N), .DATA_WIDTH(DW), .AUX_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_slot(input int i, input logic [31:0] d, input logic o, input logic [7:0] a);
      exp_t e;
      bus.slv_valid_i[i]          = 1'b1;
      bus.slv_rdata_i[i*DW +: DW] = d;
      bus.slv_opc_i[i]            = o;
      bus.slv_aux_i[i*AW +: AW]   = a;
      e.idx = i; e.rdata = d; e.opc = o; e.aux = a;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.slv_valid_i = '1;
      bus.slv_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      bus.slv_opc_i   = '1;
      bus.slv_aux_i   = 32'hdeadbeef;
      bus.mst_ready_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         vectors++;
         if (bus.tree_valid_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_tree_valid: got %b required 0000", bus.tree_valid_o);
         end
         vectors++;
         if (bus.slv_ready_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_slv_ready: got %b required 0000", bus.slv_ready_o);
         end
      end
      rst             = 1'b0;
      bus.slv_valid_i = '0;
      #1;
      vectors++;
      if (bus.slv_ready_o !== 4'b1111) begin
         miscompares++;
         $display("FAIL release_slv_ready: got %b required 1111", bus.slv_ready_o);
      end
      vectors++;
      if (bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL release_busy: got %b required 0", bus.busy_o);
      end
      next_cycle();
      vectors++;
      if (bus.tree_valid_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL release_tree_valid: got %b required 0000", bus.tree_valid_o);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      bus.mst_ready_i = 1'b1;
      for (int i = 0; i < N; i++) drive_slot(i, 32'hA0 + i, i[0], 8'h10 + 8'(i));
      next_cycle();
      bus.slv_valid_i = '0;
      for (int k = 0; k < N; k++) begin
         #1;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL rr_scoreboard: got empty queue required entry %0d", k);
         end else begin
            e = sb.pop_front();
            if (bus.tree_valid_o !== 4'(1 << e.idx) ||
                bus.tree_rdata_o[e.idx*DW +: DW] !== e.rdata ||
                bus.tree_opc_o[e.idx] !== e.opc || bus.tree_aux_o[e.idx*AW +: AW] !== e.aux) begin
               miscompares++;
               $display("FAIL rr_grant%0d: got valid %b data %h required valid %b data %h",
                        k, bus.tree_valid_o, bus.tree_rdata_o[e.idx*DW +: DW], 4'(1 << e.idx), e.rdata);
            end
         end
         next_cycle();
      end
      #1;
      vectors++;
      if (bus.tree_valid_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_drained: got valid %b busy %b required 0000 0", bus.tree_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_stall_lock();
      exp_t e;
      bus.mst_ready_i = 1'b0;
      drive_slot(2, 32'hC2, 1'b1, 8'h22);
      next_cycle();
      bus.slv_valid_i = '0;
      for (int c = 1; c <= 5; c++) begin
         if (c == 2) drive_slot(0, 32'hC0, 1'b0, 8'h20);
         #1;
         vectors++;
         if (bus.tree_valid_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_hold_c%0d: got %b required 0100", c, bus.tree_valid_o);
         end
         vectors++;
         if (bus.slv_ready_o[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_slv_ready2_c%0d: got %b required 0", c, bus.slv_ready_o[2]);
         end
         next_cycle();
         bus.slv_valid_i = '0;
      end
      bus.mst_ready_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL stall_scoreboard: got empty queue required entry %0d", k);
         end else begin
            e = sb.pop_front();
            if (bus.tree_valid_o !== 4'(1 << e.idx) ||
                bus.tree_rdata_o[e.idx*DW +: DW] !== e.rdata ||
                bus.tree_opc_o[e.idx] !== e.opc || bus.tree_aux_o[e.idx*AW +: AW] !== e.aux) begin
               miscompares++;
               $display("FAIL stall_release%0d: got valid %b data %h required valid %b data %h",
                        k, bus.tree_valid_o, bus.tree_rdata_o[e.idx*DW +: DW], 4'(1 << e.idx), e.rdata);
            end
         end
         next_cycle();
      end
      #1;
      vectors++;
      if (bus.tree_valid_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL stall_drained: got %b required 0000", bus.tree_valid_o);
      end
   endtask

   task automatic test_wrap_around();
      exp_t e;
      bus.mst_ready_i = 1'b1;
      drive_slot(2, 32'hB2, 1'b0, 8'h32);
      next_cycle();
      bus.slv_valid_i = '0;
      drive_slot(3, 32'hB3, 1'b1, 8'h33);
      drive_slot(1, 32'hB1, 1'b1, 8'h31);
      sb.pop_back();
      sb.pop_back();
      bus.slv_valid_i = '0;
      #1;
      vectors++;
      e = sb.pop_front();
      if (bus.tree_valid_o !== 4'b0100 || bus.tree_rdata_o[2*DW +: DW] !== e.rdata) begin
         miscompares++;
         $display("FAIL wrap_first: got valid %b data %h required valid 0100 data %h",
                  bus.tree_valid_o, bus.tree_rdata_o[2*DW +: DW], e.rdata);
      end
      next_cycle();
      drive_slot(3, 32'hB3, 1'b1, 8'h33);
      drive_slot(1, 32'hB1, 1'b1, 8'h31);
      next_cycle();
      bus.slv_valid_i = '0;
      for (int k = 0; k < 2; k++) begin
         #1;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL wrap_scoreboard: got empty queue required entry %0d", k);
         end else begin
            e = sb.pop_front();
            if (bus.tree_valid_o !== 4'(1 << e.idx) ||
                bus.tree_rdata_o[e.idx*DW +: DW] !== e.rdata ||
                bus.tree_opc_o[e.idx] !== e.opc || bus.tree_aux_o[e.idx*AW +: AW] !== e.aux) begin
               miscompares++;
               $display("FAIL wrap_grant%0d: got valid %b data %h required valid %b data %h",
                        k, bus.tree_valid_o, bus.tree_rdata_o[e.idx*DW +: DW], 4'(1 << e.idx), e.rdata);
            end
         end
         next_cycle();
      end
      #1;
      vectors++;
      if (bus.tree_valid_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL wrap_drained: got %b required 0000", bus.tree_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bus.mst_ready_i = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) drive_slot(1, 32'h100 + k, k[0], 8'(k));
         else bus.slv_valid_i = '0;
         #1;
         if (k < 8) begin
            vectors++;
            if (bus.slv_ready_o[1] !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b_slv_ready_%0d: got %b required 1", k, bus.slv_ready_o[1]);
            end
         end
         if (k > 0) begin
            vectors++;
            e = sb.pop_front();
            if (bus.tree_valid_o !== 4'b0010 || bus.tree_rdata_o[DW +: DW] !== e.rdata ||
                bus.tree_opc_o[1] !== e.opc || bus.tree_aux_o[AW +: AW] !== e.aux) begin
               miscompares++;
               $display("FAIL b2b_beat%0d: got valid %b data %h required valid 0010 data %h",
                        k - 1, bus.tree_valid_o, bus.tree_rdata_o[DW +: DW], e.rdata);
            end
         end
         next_cycle();
         bus.slv_valid_i = '0;
      end
      #1;
      vectors++;
      if (bus.tree_valid_o !== 4'b0000 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_drained: got valid %b pending %0d required 0000 0", bus.tree_valid_o, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bus.mst_ready_i = 1'b0;
      drive_slot(0, 32'hD0, 1'b0, 8'h40);
      drive_slot(2, 32'hD2, 1'b0, 8'h42);
      drive_slot(3, 32'hD3, 1'b0, 8'h43);
      next_cycle();
      bus.slv_valid_i = '0;
      next_cycle();
      vectors++;
      if (bus.tree_valid_o !== 4'b0100 || bus.busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_locked: got valid %b busy %b required 0100 1", bus.tree_valid_o, bus.busy_o);
      end
      rst             = 1'b1;
      bus.slv_valid_i = '1;
      next_cycle();
      rst             = 1'b0;
      bus.slv_valid_i = '0;
      sb.delete();
      #1;
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.tree_valid_o !== 4'b0000 || bus.slv_ready_o !== 4'b1111) begin
         miscompares++;
         $display("FAIL midrst_cleared: got busy %b valid %b ready %b required 0 0000 1111",
                  bus.busy_o, bus.tree_valid_o, bus.slv_ready_o);
      end
      next_cycle();
      vectors++;
      if (bus.tree_valid_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_stale: got valid %b busy %b required 0000 0", bus.tree_valid_o, bus.busy_o);
      end
      bus.mst_ready_i = 1'b1;
      drive_slot(1, 32'hE1, 1'b1, 8'h51);
      next_cycle();
      bus.slv_valid_i = '0;
      #1;
      vectors++;
      e = sb.pop_front();
      if (bus.tree_valid_o !== 4'b0010 || bus.tree_rdata_o[DW +: DW] !== e.rdata) begin
         miscompares++;
         $display("FAIL midrst_fresh: got valid %b data %h required 0010 data %h",
                  bus.tree_valid_o, bus.tree_rdata_o[DW +: DW], e.rdata);
      end
      next_cycle();
      vectors++;
      if (bus.tree_valid_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_drained: got %b required 0000", bus.tree_valid_o);
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst             = 1'b1;
      bus.slv_valid_i = '0;
      bus.slv_rdata_i = '0;
      bus.slv_opc_i   = '0;
      bus.slv_aux_i   = '0;
      bus.mst_ready_i = 1'b0;
      test_reset();
      test_round_robin();
      test_stall_lock();
      test_wrap_around();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
